// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree: one register level per binary tree level, with the
// valid bit and full channel tag carried alongside each sample.
module mux_tree_pipe #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN),
  localparam int LEVELS = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel
);

  logic [SEL_W-1:0]             r_scan_cnt;
  logic [SEL_W-1:0]             w_eff_sel;
  logic [LEVELS-1:0]            r_vld_pipe;
  logic [LEVELS-1:0][SEL_W-1:0] r_tag_pipe;

  assign w_eff_sel = mode ? r_scan_cnt : sel;

  // Counter only advances on accepted scan samples, so bubbles and
  // direct-mode traffic leave the scan position untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
    end else if (en && in_valid && mode) begin
      r_scan_cnt <= r_scan_cnt + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
    end else if (en) begin
      r_vld_pipe[0] <= in_valid;
      r_tag_pipe[0] <= w_eff_sel;
      for (int i = 1; i < LEVELS; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int N = NUM_IN >> (k + 1);
    logic [2*N-1:0][WIDTH-1:0] w_src;
    logic                      w_bit;
    logic [N-1:0][WIDTH-1:0]   r_d;

    // Level k consumes select bit k of the tag captured with its own sample.
    if (k == 0) begin : g_head
      assign w_src = in_data;
      assign w_bit = w_eff_sel[0];
    end else begin : g_body
      assign w_src = g_lvl[k-1].r_d;
      assign w_bit = r_tag_pipe[k-1][k];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_d <= '0;
      end else if (en) begin
        for (int j = 0; j < N; j++) begin
          r_d[j] <= w_bit ? w_src[2*j+1] : w_src[2*j];
        end
      end
    end
  end

  assign out_data  = g_lvl[LEVELS-1].r_d[0];
  assign out_valid = r_vld_pipe[LEVELS-1];
  assign out_sel   = r_tag_pipe[LEVELS-1];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed checks on a 4x8 tree plus a random scoreboard sweep over
// 2x1, 8x32 and 16x1 instances.
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en;
  logic [31:0] in_data;
  logic        in_valid, mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_sel;

  logic [511:0] s_data;
  logic         s_valid, s_mode;
  logic [3:0]   s_sel;
  logic [0:0]   o_data2, o_sel2;
  logic         o_valid2;
  logic [31:0]  o_data8;
  logic [2:0]   o_sel8;
  logic         o_valid8;
  logic [0:0]   o_data16;
  logic [3:0]   o_sel16;
  logic         o_valid16;

  int n_vec  = 0;
  int n_fail = 0;

  mux_tree_pipe #(.WIDTH(8), .NUM_IN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_sel(out_sel));

  mux_tree_pipe #(.WIDTH(1), .NUM_IN(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(s_data[1:0]), .in_valid(s_valid),
    .mode(s_mode), .sel(s_sel[0:0]), .out_data(o_data2), .out_valid(o_valid2), .out_sel(o_sel2));

  mux_tree_pipe #(.WIDTH(32), .NUM_IN(8)) u_n8 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(s_data[255:0]), .in_valid(s_valid),
    .mode(s_mode), .sel(s_sel[2:0]), .out_data(o_data8), .out_valid(o_valid8), .out_sel(o_sel8));

  mux_tree_pipe #(.WIDTH(1), .NUM_IN(16)) u_n16 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(s_data[15:0]), .in_valid(s_valid),
    .mode(s_mode), .sel(s_sel), .out_data(o_data16), .out_valid(o_valid16), .out_sel(o_sel16));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b1; mode = 1'b1; sel = 2'd3;
    in_data = 32'h44332211;
    tick;
    tick;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_vec++;
    if (out_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got %h want 00", out_data);
    end
    n_vec++;
    if (out_sel !== 2'd0) begin
      n_fail++; $display("FAIL reset_sel: got %0d want 0", out_sel);
    end
    rst_n = 1'b1; en = 1'b1; in_valid = 1'b0; mode = 1'b0; sel = 2'd0;
  endtask

  task automatic test_direct;
    logic [7:0] exp_d;
    in_data = 32'h44332211; mode = 1'b0; en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin sel = 2'(c); in_valid = 1'b1; end
      else begin sel = 2'd0; in_valid = 1'b0; end
      tick;
      if (c >= 1 && c <= 4) begin
        exp_d = 8'(c * 17);
        n_vec++;
        if (out_data !== exp_d || out_sel !== 2'(c - 1) || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL direct[%0d]: got d=%h s=%0d v=%b want d=%h s=%0d v=1",
                   c - 1, out_data, out_sel, out_valid, exp_d, c - 1);
        end
      end else if (c == 5) begin
        n_vec++;
        if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 8'h11) begin
          n_fail++;
          $display("FAIL direct_bubble: got d=%h s=%0d v=%b want d=11 s=0 v=0",
                   out_data, out_sel, out_valid);
        end
      end
    end
  endtask

  task automatic test_scan;
    int tags [8] = '{0, 1, 2, 3, 0, 1, 2, 2};
    bit vs   [8] = '{1, 1, 1, 1, 1, 1, 0, 1};
    logic [7:0] exp_d;
    in_data = 32'h44332211; mode = 1'b1; en = 1'b1; sel = 2'd3;
    for (int c = 0; c < 9; c++) begin
      in_valid = (c < 8) ? vs[c] : 1'b0;
      tick;
      if (c >= 1) begin
        exp_d = 8'((tags[c-1] + 1) * 17);
        n_vec++;
        if (out_data !== exp_d || out_sel !== 2'(tags[c-1]) || out_valid !== vs[c-1]) begin
          n_fail++;
          $display("FAIL scan[%0d]: got d=%h s=%0d v=%b want d=%h s=%0d v=%b",
                   c - 1, out_data, out_sel, out_valid, exp_d, tags[c-1], vs[c-1]);
        end
      end
    end
  endtask

  task automatic test_stall;
    int e_s [4] = '{2, 1, 0, 0};
    bit e_v [4] = '{1, 1, 1, 0};
    logic [7:0] exp_d;
    mode = 1'b0; en = 1'b1; in_valid = 1'b1; in_data = 32'h44332211;
    sel = 2'd3; tick;
    sel = 2'd2; tick;
    n_vec++;
    if (out_data !== 8'h44 || out_sel !== 2'd3 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_fill: got d=%h s=%0d v=%b want d=44 s=3 v=1",
                         out_data, out_sel, out_valid);
    end
    en = 1'b0; sel = 2'd0;
    for (int c = 0; c < 3; c++) begin
      tick;
      n_vec++;
      if (out_data !== 8'h44 || out_sel !== 2'd3 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got d=%h s=%0d v=%b want d=44 s=3 v=1",
                           c, out_data, out_sel, out_valid);
      end
    end
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sel = (c == 0) ? 2'd1 : 2'd0;
      in_valid = (c < 2);
      tick;
      exp_d = 8'((e_s[c] + 1) * 17);
      n_vec++;
      if (out_data !== exp_d || out_sel !== 2'(e_s[c]) || out_valid !== e_v[c]) begin
        n_fail++; $display("FAIL stall_drain[%0d]: got d=%h s=%0d v=%b want d=%h s=%0d v=%b",
                           c, out_data, out_sel, out_valid, exp_d, e_s[c], e_v[c]);
      end
    end
  endtask

  task automatic test_reset_mid;
    mode = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = 32'h44332211; sel = 2'd0;
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    n_vec++;
    if (out_data !== 8'h00 || out_sel !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: got d=%h s=%0d v=%b want d=00 s=0 v=0",
                         out_data, out_sel, out_valid);
    end
    rst_n = 1'b1;
    tick;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_flush: got v=%b want 0", out_valid);
    end
    tick;
    n_vec++;
    if (out_data !== 8'h11 || out_sel !== 2'd0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_restart0: got d=%h s=%0d v=%b want d=11 s=0 v=1",
                         out_data, out_sel, out_valid);
    end
    in_valid = 1'b0;
    tick;
    n_vec++;
    if (out_data !== 8'h22 || out_sel !== 2'd1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_restart1: got d=%h s=%0d v=%b want d=22 s=1 v=1",
                         out_data, out_sel, out_valid);
    end
  endtask

  task automatic test_mode_switch;
    bit m    [6] = '{1, 1, 0, 0, 1, 1};
    int tags [6] = '{0, 1, 0, 0, 2, 3};
    logic [7:0] exp_d;
    rst_n = 1'b0; tick; rst_n = 1'b1;
    en = 1'b1; in_data = 32'h44332211;
    for (int c = 0; c < 7; c++) begin
      if (c < 6) begin
        mode = m[c]; in_valid = 1'b1; sel = m[c] ? 2'd3 : 2'd0;
      end else begin
        mode = 1'b0; in_valid = 1'b0; sel = 2'd0;
      end
      tick;
      if (c >= 1) begin
        exp_d = 8'((tags[c-1] + 1) * 17);
        n_vec++;
        if (out_data !== exp_d || out_sel !== 2'(tags[c-1]) || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL mode_sw[%0d]: got d=%h s=%0d v=%b want d=%h s=%0d v=1",
                             c - 1, out_data, out_sel, out_valid, exp_d, tags[c-1]);
        end
      end
    end
  endtask

  task automatic test_sweep;
    logic [36:0] q2[$], q8[$], q16[$];
    logic [36:0] exp_v, act_v;
    int c2 = 0, c8 = 0, c16 = 0;
    int e2, e8, e16;
    rst_n = 1'b0; tick; rst_n = 1'b1;
    for (int t = 0; t < 300; t++) begin
      for (int w = 0; w < 16; w++) s_data[w*32 +: 32] = $urandom();
      s_sel   = 4'($urandom_range(0, 15));
      s_valid = ($urandom_range(0, 3) != 0);
      s_mode  = ($urandom_range(0, 3) == 0);
      en      = ($urandom_range(0, 7) != 0);
      if (en) begin
        e2  = s_mode ? c2  : int'(s_sel[0]);
        e8  = s_mode ? c8  : int'(s_sel[2:0]);
        e16 = s_mode ? c16 : int'(s_sel);
        q2.push_back({s_valid, 4'(e2), 32'(s_data[e2])});
        q8.push_back({s_valid, 4'(e8), s_data[e8*32 +: 32]});
        q16.push_back({s_valid, 4'(e16), 32'(s_data[e16])});
        if (s_valid && s_mode) begin
          c2 = (c2 + 1) % 2; c8 = (c8 + 1) % 8; c16 = (c16 + 1) % 16;
        end
      end
      tick;
      if (en) begin
        if (q2.size() == 1) begin
          exp_v = q2.pop_front(); act_v = {o_valid2, 4'(o_sel2), 32'(o_data2)};
          n_vec++;
          if (act_v !== exp_v) begin
            n_fail++; $display("FAIL sweep_n2[%0d]: got %h want %h", t, act_v, exp_v);
          end
        end
        if (q8.size() == 3) begin
          exp_v = q8.pop_front(); act_v = {o_valid8, 4'(o_sel8), o_data8};
          n_vec++;
          if (act_v !== exp_v) begin
            n_fail++; $display("FAIL sweep_n8[%0d]: got %h want %h", t, act_v, exp_v);
          end
        end
        if (q16.size() == 4) begin
          exp_v = q16.pop_front(); act_v = {o_valid16, 4'(o_sel16), 32'(o_data16)};
          n_vec++;
          if (act_v !== exp_v) begin
            n_fail++; $display("FAIL sweep_n16[%0d]: got %h want %h", t, act_v, exp_v);
          end
        end
      end
    end
    en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in_data = '0; in_valid = 1'b0; mode = 1'b0; sel = '0;
    s_data = '0; s_valid = 1'b0; s_mode = 1'b0; s_sel = '0;
    test_reset;
    test_direct;
    test_scan;
    test_stall;
    test_reset_mid;
    test_mode_switch;
    test_sweep;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
Parametrised, pipelined N-to-1 multiplexer built as a binary tree of 2:1 select stages, with one register level per tree level. A valid bit and a channel tag travel alongside the data. Channel selection is either supplied by the caller (direct mode) or generated internally by a rotating scan counter (scan mode). Used wherever several equal-width sources share one downstream consumer at full clock rate.

Parameters:
WIDTH, 8, data width per channel in bits (>=1)
NUM_IN, 4, number of input channels; power of two, >=2
SEL_W, $clog2(NUM_IN), select/tag width; derived, must not be overridden
LEVELS, $clog2(NUM_IN), tree depth and pipeline latency in cycles; derived

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
en  input  1  pipeline advance; 0 freezes every register in the block
in_data  input  NUM_IN*WIDTH  flat channel bus; channel i = in_data[i*WIDTH +: WIDTH]
in_valid  input  1  qualifies the current sample
mode  input  1  0 = direct (use sel), 1 = scan (use internal counter)
sel  input  SEL_W  channel select in direct mode; ignored in scan mode
out_data  output  WIDTH  selected channel data, registered
out_valid  output  1  qualifies out_data
out_sel  output  SEL_W  channel index that produced out_data

Behaviour:
- Reset (rst_n=0 at a clk edge): all pipeline data, valid and tag registers clear to 0; scan counter clears to 0. Reset wins over en. Outputs read 0 on the cycle after reset is sampled. Reset mid-stream discards all in-flight samples with no partial output.
- Effective select: eff_sel = sel when mode=0, scan_cnt when mode=1. It is sampled together with in_data and in_valid on the same edge.
- Tree: level k (k=0..LEVELS-1) pairs adjacent candidates 2j and 2j+1 and picks 2j+1 when eff_sel[k]=1, else 2j. Level 0 uses the LSB. Each level's result is registered. The remaining upper select bits and the full tag are delayed alongside so each level uses the bits captured with its own sample.
- Latency: exactly LEVELS enabled cycles from input sample to out_data/out_valid/out_sel. Throughput is one sample per enabled cycle.
- in_valid=0 samples propagate as bubbles: out_valid=0. Data registers still load, so out_data is don't-care but deterministic. out_sel always equals the eff_sel of the same sample.
- en=0: no register changes, including the scan counter. Outputs hold their values, and out_valid stays asserted if it was asserted.
- Scan counter increments by 1 only on edges where en=1, in_valid=1 and mode=1. It wraps from NUM_IN-1 to 0.
- Mode switching: takes effect on the very next sample. The counter value is retained across direct-mode periods and is not reset by a mode change.
- NUM_IN=2: single level, latency 1. The scan counter toggles 0,1,0,...

Test Plan:
1. Direct mode, NUM_IN=4, WIDTH=8, channels {0x11,0x22,0x33,0x44}, in_valid=1, sel stepping 0,1,2,3 on consecutive cycles -> after 2 cycles out_data is 0x11,0x22,0x33,0x44 on consecutive cycles, with out_sel 0..3 and out_valid=1.
2. Scan mode, continuous in_valid=1 for 6 cycles with fixed channel data -> out_sel is 0,1,2,3,0,1 and out_data matches each channel. Insert in_valid=0 for 1 cycle -> counter does not advance and out_valid=0 appears at that slot.
3. Stall: en=0 for 3 cycles while the pipeline is full -> outputs hold. On en=1 the remaining samples emerge in order and none are lost or duplicated.
4. Reset mid-stream: assert rst_n=0 for 1 cycle with 2 samples in flight -> next cycle out_valid=0, out_data=0, out_sel=0. The scan restarts at channel 0.
5. Mode switch: scan to count=2, then 2 direct samples with sel=0, then return to scan -> scan resumes at channel 2.
6. Parameter sweep NUM_IN in {2,8,16}, WIDTH in {1,32}, with random sel and in_valid -> scoreboard confirms latency=LEVELS and bit-exact selection.
